mem_access_unit: RTL and testbench

// - Initiator side of the word-wide, byte-addressed, big-endian data-memory port. The byte at addr
//   is bits [31:24]. The memory reads combinationally and writes on the clock edge when WE=1.
// - Sits between the pipeline MEM stage and data memory.
// - Executes LW/LH/LHU/LB/LBU/SW/SH/SB using only aligned word accesses.
//   Sub-word stores are done as a read-modify-write sequence.
// - Flags misaligned or out-of-range requests and never touches memory for them.

---
 rtl/mem_access_unit_pkg.sv | 49 ++++
 rtl/mem_access_unit_byte_lane.sv | 57 +++++
 rtl/mem_access_unit.sv | 120 ++++++++++++
 tb/tb_mem_access_unit.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit:
// op codes, FSM states and small decode helpers.
package mem_access_defs;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  function automatic logic is_store(input op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Access size in bytes: 1, 2 or 4.
  function automatic logic [2:0] access_size(input op_e op);
    logic [2:0] sz;
    unique case (op)
      OP_LW, OP_SW:         sz = 3'd4;
      OP_LH, OP_LHU, OP_SH: sz = 3'd2;
      default:              sz = 3'd1;
    endcase
    return sz;
  endfunction

  function automatic logic misaligned(input op_e op,
                                      input logic [1:0] off);
    logic bad;
    unique case (access_size(op))
      3'd4:    bad = (off != 2'b00);
      3'd2:    bad = off[0];
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane.sv
// Big-endian lane logic: extracts and extends load data,
// and merges sub-word store data into the old word.
module byte_lane_unit
  import mem_access_defs::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  op_e         op,
  input  logic [31:0] data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  b;
  logic [15:0] h;

  // Select the addressed byte and halfword lane.
  always_comb begin
    b = word[7:0];
    unique case (offset)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = offset[1] ? word[15:0] : word[31:16];
  end

  // Sign/zero extension of the selected lane for loads.
  always_comb begin
    load_data = word;
    unique case (op)
      OP_LB:   load_data = {{24{b[7]}}, b};
      OP_LBU:  load_data = {24'd0, b};
      OP_LH:   load_data = {{16{h[15]}}, h};
      OP_LHU:  load_data = {16'd0, h};
      default: load_data = word;
    endcase
  end

  // Replace only the addressed lane for sub-word stores.
  always_comb begin
    merged = word;
    if (op == OP_SB) begin
      unique case (offset)
        2'd0:    merged[31:24] = data[7:0];
        2'd1:    merged[23:16] = data[7:0];
        2'd2:    merged[15:8]  = data[7:0];
        default: merged[7:0]   = data[7:0];
      endcase
    end else if (op == OP_SH) begin
      if (offset[1]) merged[15:0]  = data[15:0];
      else           merged[31:16] = data[15:0];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator: word-only accesses, sub-word
// stores via read-modify-write, error flagging.
module mem_access_unit
  import mem_access_defs::*;
#(
  parameter int MEM_BYTES = 12288
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rdata
);

  state_e      state;
  op_e         op_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  op_e         op_in;
  logic [32:0] end_addr;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign op_in = op_e'(req_op);
  // Last byte touched must stay inside the memory.
  assign end_addr = {1'b0, req_addr}
                  + {30'd0, access_size(op_in)};
  assign req_err = misaligned(op_in, req_addr[1:0])
                 || (end_addr > 33'(MEM_BYTES));
  assign req_ready = (state == IDLE);

  byte_lane_unit u_lane (
    .word      (mem_rdata),
    .offset    (off_q),
    .op        (op_q),
    .data      (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // Access sequencer with registered memory and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_LW;
      off_q      <= 2'd0;
      wdata_q    <= 32'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_pc     <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            op_q       <= op_in;
            off_q      <= req_addr[1:0];
            wdata_q    <= req_wdata;
            mem_pc     <= req_pc;
            resp_rdata <= 32'd0;
            resp_err   <= req_err;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              mem_addr <= {req_addr[31:2], 2'b00};
              if (op_in == OP_SW) begin
                state     <= WR;
                mem_we    <= 1'b1;
                mem_wdata <= req_wdata;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: begin
          if (is_store(op_q)) begin
            state     <= WR;
            mem_we    <= 1'b1;
            mem_wdata <= merged;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
          end
        end
        WR: begin
          mem_we     <= 1'b0;
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a simple
// combinational-read word memory model.
module tb_mem_access_unit;

  localparam int WORDS = 3072;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_pc;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:WORDS-1];
  int          we_cnt;
  logic [31:0] last_wdata;
  int          vectors;
  int          miscompares;

  mem_access_unit #(.MEM_BYTES(12288)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_pc     (mem_pc),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr[31:2] < 30'(WORDS))
                   ? mem[mem_addr[13:2]] : 32'd0;

  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt <= we_cnt + 1;
      last_wdata <= mem_wdata;
      if (mem_addr[31:2] < 30'(WORDS))
        mem[mem_addr[13:2]] <= mem_wdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_req(input logic [2:0] op,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        output int lat,
                        output logic [31:0] rdata,
                        output logic err);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_pc    = req_pc + 32'd4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_req_ready got %b exp 1", req_ready);
    end
    vectors++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_resp got v=%b e=%b exp 0/0",
               resp_valid, resp_err);
    end
    vectors++;
    if (resp_rdata !== 32'd0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rdata_we got %h/%b exp 0/0",
               resp_rdata, mem_we);
    end
    vectors++;
    if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mem got %h/%h exp 0/0",
               mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sw_lw;
    int lat;
    logic [31:0] rd;
    logic er;
    int w0;
    w0 = we_cnt;
    do_req(3'd5, 32'h10, 32'h11223344, lat, rd, er);
    vectors++;
    if (we_cnt - w0 !== 1) begin
      miscompares++;
      $display("FAIL sw_we_cycles got %0d exp 1", we_cnt - w0);
    end
    vectors++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'd0) begin
      miscompares++;
      $display("FAIL sw_resp got lat=%0d e=%b d=%h exp 2/0/0",
               lat, er, rd);
    end
    vectors++;
    if (mem[4] !== 32'h11223344) begin
      miscompares++;
      $display("FAIL sw_mem got %h exp 11223344", mem[4]);
    end
    do_req(3'd0, 32'h10, 32'h0, lat, rd, er);
    vectors++;
    if (lat !== 2 || rd !== 32'h11223344 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL lw got lat=%0d d=%h e=%b exp 2/11223344/0",
               lat, rd, er);
    end
  endtask

  task automatic test_sb_rmw;
    int lat;
    logic [31:0] rd;
    logic er;
    int w0;
    w0 = we_cnt;
    do_req(3'd7, 32'h12, 32'h000000AB, lat, rd, er);
    vectors++;
    if (lat !== 3 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_latency got %0d/%b exp 3/0", lat, er);
    end
    vectors++;
    if (we_cnt - w0 !== 1 || last_wdata !== 32'h1122AB44) begin
      miscompares++;
      $display("FAIL sb_write got n=%0d d=%h exp 1/1122ab44",
               we_cnt - w0, last_wdata);
    end
    vectors++;
    if (mem[4] !== 32'h1122AB44) begin
      miscompares++;
      $display("FAIL sb_mem got %h exp 1122ab44", mem[4]);
    end
    do_req(3'd6, 32'h16, 32'hFFFFBEEF, lat, rd, er);
    vectors++;
    if (lat !== 3 || mem[5][15:0] !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL sh_lo got lat=%0d d=%h exp 3/....beef",
               lat, mem[5]);
    end
  endtask

  task automatic test_load_ext;
    int lat;
    logic [31:0] rd;
    logic er;
    logic [2:0]  ops [6];
    logic [31:0] adr [6];
    logic [31:0] exp [6];
    ops = '{3'd3, 3'd4, 3'd1, 3'd1, 3'd2, 3'd3};
    adr = '{32'h20, 32'h20, 32'h22, 32'h20, 32'h20, 32'h23};
    exp = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01,
            32'hFFFF80FF, 32'h000080FF, 32'h00000001};
    do_req(3'd5, 32'h20, 32'h80FF7F01, lat, rd, er);
    for (int i = 0; i < 6; i++) begin
      do_req(ops[i], adr[i], 32'h0, lat, rd, er);
      vectors++;
      if (rd !== exp[i] || lat !== 2 || er !== 1'b0) begin
        miscompares++;
        $display("FAIL load_ext[%0d] got %h lat=%0d exp %h lat=2",
                 i, rd, lat, exp[i]);
      end
    end
  endtask

  task automatic test_errors;
    int lat;
    logic [31:0] rd;
    logic er;
    int w0;
    logic [2:0]  ops [4];
    logic [31:0] adr [4];
    ops = '{3'd0, 3'd6, 3'd5, 3'd7};
    adr = '{32'h13, 32'h11, 32'h3000, 32'h3000};
    w0 = we_cnt;
    for (int i = 0; i < 4; i++) begin
      do_req(ops[i], adr[i], 32'hFFFFFFFF, lat, rd, er);
      vectors++;
      if (er !== 1'b1 || lat !== 1 || rd !== 32'd0) begin
        miscompares++;
        $display("FAIL err[%0d] got e=%b lat=%0d d=%h exp 1/1/0",
                 i, er, lat, rd);
      end
    end
    vectors++;
    if (we_cnt !== w0) begin
      miscompares++;
      $display("FAIL err_no_write got %0d writes exp 0",
               we_cnt - w0);
    end
    do_req(3'd0, 32'h2FFC, 32'h0, lat, rd, er);
    vectors++;
    if (er !== 1'b0 || lat !== 2) begin
      miscompares++;
      $display("FAIL last_word got e=%b lat=%0d exp 0/2", er, lat);
    end
  endtask

  task automatic test_backpressure;
    int n;
    int w0;
    int lat;
    logic [31:0] rd;
    logic er;
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_addr  = 32'h10;
    @(posedge clk); #1;
    req_op    = 3'd5;
    req_addr  = 32'h40;
    req_wdata = 32'h5A5A5A5A;
    w0 = we_cnt;
    n = 0;
    while (!resp_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h1122AB44
          || req_ready !== 1'b0 || mem_we !== 1'b0) begin
        miscompares++;
        $display("FAIL hold[%0d] got v=%b d=%h rr=%b we=%b",
                 i, resp_valid, resp_rdata, req_ready, mem_we);
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0
        || we_cnt !== w0) begin
      miscompares++;
      $display("FAIL after_hs got rr=%b v=%b writes=%0d exp 1/0/0",
               req_ready, resp_valid, we_cnt - w0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    vectors++;
    if (req_ready !== 1'b0 || mem_we !== 1'b1) begin
      miscompares++;
      $display("FAIL pending_accept got rr=%b we=%b exp 0/1",
               req_ready, mem_we);
    end
    n = 0;
    while (!resp_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    do_req(3'd0, 32'h40, 32'h0, lat, rd, er);
    vectors++;
    if (rd !== 32'h5A5A5A5A) begin
      miscompares++;
      $display("FAIL pending_data got %h exp 5a5a5a5a", rd);
    end
  endtask

  task automatic test_reset_mid_rmw;
    int lat;
    logic [31:0] rd;
    logic er;
    int w0;
    do_req(3'd5, 32'h30, 32'hCAFEBABE, lat, rd, er);
    req_valid = 1'b1;
    req_op    = 3'd7;
    req_addr  = 32'h31;
    req_wdata = 32'h00000077;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    w0 = we_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0
        || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_rmw got rr=%b v=%b we=%b exp 1/0/0",
               req_ready, resp_valid, mem_we);
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (we_cnt !== w0 || mem[12] !== 32'hCAFEBABE) begin
      miscompares++;
      $display("FAIL rst_rmw_mem got writes=%0d d=%h exp 0/cafebabe",
               we_cnt - w0, mem[12]);
    end
    do_req(3'd0, 32'h30, 32'h0, lat, rd, er);
    vectors++;
    if (rd !== 32'hCAFEBABE || lat !== 2) begin
      miscompares++;
      $display("FAIL rst_rmw_reload got %h lat=%0d exp cafebabe/2",
               rd, lat);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    we_cnt      = 0;
    last_wdata  = 32'd0;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_op      = 3'd0;
    req_addr    = 32'd0;
    req_wdata   = 32'd0;
    req_pc      = 32'h1000;
    resp_ready  = 1'b0;
    test_reset();
    test_sw_lw();
    test_sb_rmw();
    test_load_ext();
    test_errors();
    test_backpressure();
    test_reset_mid_rmw();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
